// File: rtl/ram_bridge_pkg.sv
// Shared types for the core-to-halfword-RAM bridge: access sizes, FSM states,
// the registered request, and the request legality check.
package ram_bridge_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_WAIT,
    WR_LO,
    WR_HI,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  typedef struct packed {
    logic      we;
    mem_size_t size;
    logic      uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Misaligned, size 11, or any touched halfword index past the end of the RAM.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] depth);
    logic [31:0] hw0;
    logic        err;
    hw0 = {1'b0, addr[31:1]};
    case (size)
      2'b00:   err = (hw0 >= depth);
      2'b01:   err = addr[0] || (hw0 >= depth);
      2'b10:   err = (addr[1:0] != 2'b00) || ((hw0 + 32'd1) >= depth);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ram_bridge_if.sv
// Core request/response and halfword RAM port bundle; the bridge is the slave,
// the core plus RAM side is the master.
interface ram_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic [31:0] ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rd_data,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rd_data,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en
  );
endinterface

// File: rtl/ram_bridge_load_extend.sv
// Combinational load lane select and sign/zero extension; zero latency, no flow control.
// Word data arrives as {hi, lo}; byte/half data sits in bits [15:0].
module load_extend
  import ram_bridge_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic        addr0_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0] byte_lane;

  always_comb begin
    byte_lane = addr0_i ? data_i[15:8] : data_i[7:0];
    case (size_i)
      BYTE:    data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      HALF:    data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/ram_bridge.sv
// Bridges byte/half/word core accesses onto a 16-bit RAM; one request in flight,
// response 1-4 cycles after accept, req_ready only while idle.
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int DEPTH = 8192
) (
  input  logic        clk,
  input  logic        reset,
  ram_bridge_if.slave bus
);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [15:0] lo_q, lo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [31:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [31:0] hw0, hw1;
  logic [31:0] ext_in, ext_out;

  assign hw0 = {1'b0, req_q.addr[31:1]};
  assign hw1 = hw0 + 32'd1;

  // The high half of a word is still on ram_rd_data when the response is built.
  assign ext_in = (req_q.size == WORD) ? {bus.ram_rd_data, lo_q} : {16'h0000, bus.ram_rd_data};

  load_extend u_load_extend (
    .data_i     (ext_in),
    .addr0_i    (req_q.addr[0]),
    .size_i     (req_q.size),
    .unsigned_i (req_q.uns),
    .data_o     (ext_out)
  );

  assign bus.req_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    lo_d        = lo_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    rd_addr     = 32'h0;
    wr_addr     = 32'h0;
    wr_data     = 16'h0;
    wr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          req_d.we    = bus.req_we;
          req_d.size  = mem_size_t'(bus.req_size);
          req_d.uns   = bus.req_unsigned;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          if (access_err(bus.req_size, bus.req_addr, 32'(DEPTH))) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else if (!bus.req_we) begin
            state_d = RD_LO;
          end else if (bus.req_size == BYTE) begin
            state_d = RMW_RD;
          end else begin
            state_d = WR_LO;
          end
        end
      end
      RD_LO: begin
        rd_addr = hw0;
        state_d = (req_q.size == WORD) ? RD_HI : RD_WAIT;
      end
      RD_HI: begin
        rd_addr = hw1;
        lo_d    = bus.ram_rd_data;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_rdata_d = ext_out;
        state_d     = RESP;
      end
      WR_LO: begin
        wr_en   = 1'b1;
        wr_addr = hw0;
        wr_data = req_q.wdata[15:0];
        state_d = (req_q.size == WORD) ? WR_HI : RESP;
      end
      WR_HI: begin
        wr_en   = 1'b1;
        wr_addr = hw1;
        wr_data = req_q.wdata[31:16];
        state_d = RESP;
      end
      RMW_RD: begin
        rd_addr = hw0;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        wr_en   = 1'b1;
        wr_addr = hw0;
        wr_data = req_q.addr[0] ? {req_q.wdata[7:0], bus.ram_rd_data[7:0]}
                                : {bus.ram_rd_data[15:8], req_q.wdata[7:0]};
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      lo_q        <= 16'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.ram_rd_addr = rd_addr;
  assign bus.ram_wr_addr = wr_addr;
  assign bus.ram_wr_data = wr_data;
  assign bus.ram_wr_en   = wr_en;

endmodule

// File: tb/tb_ram_bridge.sv
// Directed bench for ram_bridge with a behavioural 8K x 16 synchronous-read RAM.
module tb_ram_bridge;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_bridge_if bus ();

  ram_bridge #(.DEPTH(8192)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit [15:0] mem [0:8191];
  int wr_cnt = 0;
  int rsp_cnt = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (bus.ram_wr_en) begin
      if (bus.ram_wr_addr < 32'd8192) mem[bus.ram_wr_addr[12:0]] <= bus.ram_wr_data;
      wr_cnt++;
    end
    bus.ram_rd_data <= (bus.ram_rd_addr < 32'd8192) ? mem[bus.ram_rd_addr[12:0]] : 16'h0000;
    if (bus.rsp_valid) rsp_cnt++;
    if (bus.req_valid && bus.req_ready) acc_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One request, with the inputs scrambled right after accept to prove they were registered.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rdata, input int exp_nwr);
    int k;
    int lat;
    int w0;
    logic err;
    logic [31:0] rdata;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_unsigned = ~uns;
    bus.req_addr     = ~addr;
    bus.req_wdata    = ~wdata;
    check_val({tag, "_busy"}, {31'b0, bus.req_ready}, 32'd0);
    lat = 1;
    while (!bus.rsp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    err   = bus.rsp_err;
    rdata = bus.rsp_rdata;
    @(posedge clk);
    #1;
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check_val({tag, "_rdata"}, rdata, exp_rdata);
    check_val({tag, "_nwr"}, wr_cnt - w0, exp_nwr);
    check_val({tag, "_pulse"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    int k;
    int w0;
    int r0;
    int a0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check_val("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check_val("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_val("rst_wr_en", {31'b0, bus.ram_wr_en}, 32'd0);
    check_val("rst_ram_addrs", bus.ram_rd_addr | bus.ram_wr_addr, 32'h0);
    check_val("rst_wr_data", {16'h0, bus.ram_wr_data}, 32'h0);
    check_val("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rel_ready", {31'b0, bus.req_ready}, 32'd1);

    xact("st_w10", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0, 2);
    check_val("mem8", {16'h0, mem[8]}, 32'hBEEF);
    check_val("mem9", {16'h0, mem[9]}, 32'hDEAD);
    xact("ld_w10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hDEADBEEF, 0);

    xact("st_b11", 1'b1, SZ_B, 1'b0, 32'h11, 32'h12345680, 3, 1'b0, 32'h0, 1);
    check_val("mem8_rmw", {16'h0, mem[8]}, 32'h80EF);
    check_val("mem9_keep", {16'h0, mem[9]}, 32'hDEAD);
    xact("ld_bs11", 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 3, 1'b0, 32'hFFFFFF80, 0);
    xact("ld_bu11", 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 3, 1'b0, 32'h00000080, 0);
    xact("ld_bs10", 1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hFFFFFFEF, 0);
    xact("ld_hu12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 3, 1'b0, 32'h0000DEAD, 0);
    xact("ld_hs12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 3, 1'b0, 32'hFFFFDEAD, 0);
    xact("ld_w10b", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hDEAD80EF, 0);

    xact("st_h20", 1'b1, SZ_H, 1'b0, 32'h20, 32'hAAAA1234, 2, 1'b0, 32'h0, 1);
    check_val("mem10", {16'h0, mem[16]}, 32'h1234);
    xact("st_b20", 1'b1, SZ_B, 1'b0, 32'h20, 32'hFFFFFF56, 3, 1'b0, 32'h0, 1);
    xact("ld_hu20", 1'b0, SZ_H, 1'b1, 32'h20, 32'h0, 3, 1'b0, 32'h00001256, 0);

    xact("err_h3", 1'b0, SZ_H, 1'b0, 32'h3, 32'h0, 1, 1'b1, 32'h0, 0);
    xact("err_w2", 1'b0, SZ_W, 1'b0, 32'h2, 32'h0, 1, 1'b1, 32'h0, 0);
    xact("err_sz3", 1'b0, SZ_X, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0);
    xact("err_stw", 1'b1, SZ_W, 1'b0, 32'h4000, 32'h11223344, 1, 1'b1, 32'h0, 0);
    xact("err_ldb", 1'b0, SZ_B, 1'b1, 32'h4000, 32'h0, 1, 1'b1, 32'h0, 0);
    xact("st_wtop", 1'b1, SZ_W, 1'b0, 32'h3FFC, 32'h9ABC5678, 3, 1'b0, 32'h0, 2);
    xact("ld_wtop", 1'b0, SZ_W, 1'b0, 32'h3FFC, 32'h0, 4, 1'b0, 32'h9ABC5678, 0);

    // Reset while the low half of a word store is being written.
    w0 = wr_cnt;
    r0 = rsp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = SZ_W;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h11112222;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_val("abort_in_wrlo", {31'b0, bus.ram_wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("abort_wr_en", {31'b0, bus.ram_wr_en}, 32'd0);
    check_val("abort_ready", {31'b0, bus.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("abort_rel_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_no_rsp", rsp_cnt - r0, 32'd0);
    check_val("abort_no_wr", wr_cnt - w0, 32'd0);
    check_val("abort_mem19", {16'h0, mem[25]}, 32'h0);
    check_val("abort_mem18", {16'h0, mem[24]}, 32'h0);

    // req_valid held high across three half stores.
    w0 = wr_cnt;
    r0 = rsp_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = SZ_H;
      bus.req_addr  = 32'h40 + 32'(2 * i);
      bus.req_wdata = 32'hA001 + 32'(i);
      k = 0;
      while (!bus.req_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_val("b2b_ready_seen", {31'b0, (k < 20)}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("b2b_accepts", acc_cnt - a0, 32'd3);
    check_val("b2b_rsps", rsp_cnt - r0, 32'd3);
    check_val("b2b_writes", wr_cnt - w0, 32'd3);
    check_val("b2b_mem20", {16'h0, mem[32]}, 32'hA001);
    check_val("b2b_mem21", {16'h0, mem[33]}, 32'hA002);
    check_val("b2b_mem22", {16'h0, mem[34]}, 32'hA003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
